// File: rtl/jtag_host_ctrl_pkg.sv
// Shared definitions for the JTAG host controller and its TAP next-state function.
// - DW / LW        : maximum scan length in bits and the width of the LEN field
// - tap_state_e    : 16-state TAP encoding, identical to the target-side decoder
// - seq_state_e    : host sequencer states
// - RstCnt         : countdown start for the TMS-only reset walk
package jtag_host_ctrl_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = $clog2(DW);

    typedef enum logic [3:0] {
        TapTlr     = 4'd0,
        TapRti     = 4'd1,
        TapSelDr   = 4'd2,
        TapSelIr   = 4'd3,
        TapCapDr   = 4'd4,
        TapShDr    = 4'd5,
        TapEx1Dr   = 4'd6,
        TapPauseDr = 4'd7,
        TapEx2Dr   = 4'd8,
        TapUpDr    = 4'd9,
        TapCapIr   = 4'd10,
        TapShIr    = 4'd11,
        TapEx1Ir   = 4'd12,
        TapPauseIr = 4'd13,
        TapEx2Ir   = 4'd14,
        TapUpIr    = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        StRstSeq,
        StIdle,
        StPre,
        StShift,
        StPost
    } seq_state_e;

    // Five TMS=1 cycles, one TMS=0 cycle, then DONE: counts 5..2 -> 1, 1 -> 0, 0 -> done.
    localparam logic [LW-1:0] RstCnt = LW'(5);

endpackage

// File: rtl/jtag_host_ctrl_if.sv
// Command and pin bundle of the JTAG host controller.
// - start/ir_sel/len/data_in/tap_rst : scan or reset request from the command source
// - tdo                              : target serial output
// - tms/tdi                          : registered pins to the target
// - busy/done/data_out/tap_state     : status, captured TDO bits, modelled TAP state
// master: command source / pin environment; slave: the controller.
interface jtag_host_ctrl_if;
    import jtag_host_ctrl_pkg::*;

    logic          start;
    logic          ir_sel;
    logic [LW-1:0] len;
    logic [DW-1:0] data_in;
    logic          tap_rst;
    logic          tdo;
    logic          tms;
    logic          tdi;
    logic          busy;
    logic          done;
    logic [DW-1:0] data_out;
    logic [3:0]    tap_state;

    modport master (
        output start, ir_sel, len, data_in, tap_rst, tdo,
        input  tms, tdi, busy, done, data_out, tap_state
    );

    modport slave (
        input  start, ir_sel, len, data_in, tap_rst, tdo,
        output tms, tdi, busy, done, data_out, tap_state
    );

endinterface

// File: rtl/jtag_tap_next.sv
// Combinational IEEE 1149.1 TAP next-state function.
// - state_i : current TAP state
// - tms_i   : TMS sampled on the coming TCK rising edge
// - state_o : TAP state after that edge
module jtag_tap_next
    import jtag_host_ctrl_pkg::*;
(
    input  tap_state_e state_i,
    input  logic       tms_i,
    output tap_state_e state_o
);

    always_comb begin
        state_o = TapTlr;
        unique case (state_i)
            TapTlr:     state_o = tms_i ? TapTlr   : TapRti;
            TapRti:     state_o = tms_i ? TapSelDr : TapRti;
            TapSelDr:   state_o = tms_i ? TapSelIr : TapCapDr;
            TapSelIr:   state_o = tms_i ? TapTlr   : TapCapIr;
            TapCapDr:   state_o = tms_i ? TapEx1Dr : TapShDr;
            TapShDr:    state_o = tms_i ? TapEx1Dr : TapShDr;
            TapEx1Dr:   state_o = tms_i ? TapUpDr  : TapPauseDr;
            TapPauseDr: state_o = tms_i ? TapEx2Dr : TapPauseDr;
            TapEx2Dr:   state_o = tms_i ? TapUpDr  : TapShDr;
            TapUpDr:    state_o = tms_i ? TapSelDr : TapRti;
            TapCapIr:   state_o = tms_i ? TapEx1Ir : TapShIr;
            TapShIr:    state_o = tms_i ? TapEx1Ir : TapShIr;
            TapEx1Ir:   state_o = tms_i ? TapUpIr  : TapPauseIr;
            TapPauseIr: state_o = tms_i ? TapEx2Ir : TapPauseIr;
            TapEx2Ir:   state_o = tms_i ? TapUpIr  : TapShIr;
            TapUpIr:    state_o = tms_i ? TapSelDr : TapRti;
        endcase
    end

endmodule

// File: rtl/jtag_host_ctrl.sv
// JTAG host controller: turns one "scan N bits into IR or DR" request (or a TAP reset
// request) into the TMS/TDI walk, captures TDO and tracks the target TAP state.
// - tck_i  : JTAG clock, all logic on the rising edge
// - rst_i  : synchronous active-high reset; restarts the TMS reset walk
// - bus_if : command, status and pin bundle (slave side)
module jtag_host_ctrl
    import jtag_host_ctrl_pkg::*;
(
    input  logic tck_i,
    input  logic rst_i,
    jtag_host_ctrl_if.slave bus_if
);

    seq_state_e    st_q, st_d;
    tap_state_e    tap_q, tap_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] cap_q, cap_d;
    logic          ir_q, ir_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          tms_q, tms_d;
    logic          tdi_q, tdi_d;
    logic          done_q, done_d;
    logic          acc_rst, acc_scan;

    // TAP model advances on the TMS that was on the pin during the cycle just ending.
    jtag_tap_next u_tap_next (
        .state_i (tap_q),
        .tms_i   (tms_q),
        .state_o (tap_d)
    );

    // TAP_RST has priority over START when both arrive together.
    assign acc_rst  = (st_q == StIdle) && bus_if.tap_rst;
    assign acc_scan = (st_q == StIdle) && !bus_if.tap_rst && bus_if.start && (tap_q == TapRti);

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            st_q   <= StRstSeq;
            tap_q  <= TapTlr;
            cnt_q  <= RstCnt;
            cap_q  <= '0;
            ir_q   <= 1'b0;
            len_q  <= '0;
            sh_q   <= '0;
            dout_q <= '0;
            tms_q  <= 1'b1;
            tdi_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            tap_q  <= tap_d;
            cnt_q  <= cnt_d;
            cap_q  <= cap_d;
            ir_q   <= ir_d;
            len_q  <= len_d;
            sh_q   <= sh_d;
            dout_q <= dout_d;
            tms_q  <= tms_d;
            tdi_q  <= tdi_d;
            done_q <= done_d;
        end
    end

    // Sequencer next state, counters, shift and capture registers.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        cap_d  = cap_q;
        ir_d   = ir_q;
        len_d  = len_q;
        sh_d   = sh_q;
        dout_d = dout_q;
        unique case (st_q)
            StRstSeq: begin
                if (cnt_q == '0) st_d = StIdle;
                else             cnt_d = cnt_q - LW'(1);
            end
            StIdle: begin
                if (acc_rst) begin
                    st_d  = StRstSeq;
                    cnt_d = RstCnt;
                end else if (acc_scan) begin
                    st_d   = StPre;
                    ir_d   = bus_if.ir_sel;
                    len_d  = bus_if.len;
                    sh_d   = bus_if.data_in;
                    // Remaining preamble cycles after the first TMS=1 driven now.
                    cnt_d  = bus_if.ir_sel ? LW'(2) : LW'(1);
                    cap_d  = '0;
                    dout_d = '0;
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    st_d  = StShift;
                    cnt_d = len_q;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            StShift: begin
                sh_d = sh_q >> 1;
                if (cnt_q == '0) begin
                    st_d  = StPost;
                    cnt_d = LW'(2);
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end
            StPost: begin
                if (cnt_q == '0) st_d = StIdle;
                else             cnt_d = cnt_q - LW'(1);
            end
            default: st_d = StRstSeq;
        endcase
        if ((tap_q == TapShIr) || (tap_q == TapShDr)) begin
            dout_d[cap_q] = bus_if.tdo;
            cap_d         = cap_q + LW'(1);
        end
    end

    // Pin values for the next cycle and the DONE pulse.
    always_comb begin
        tms_d  = 1'b0;
        tdi_d  = 1'b0;
        done_d = 1'b0;
        unique case (st_q)
            StRstSeq: begin
                tms_d  = (cnt_q > LW'(1));
                done_d = (cnt_q == '0);
            end
            StIdle:  tms_d = acc_rst || acc_scan;
            StPre:   tms_d = ir_q && (cnt_q == LW'(2));
            StShift: begin
                tms_d = (cnt_q == '0);
                tdi_d = sh_q[0];
            end
            StPost: begin
                tms_d  = (cnt_q == LW'(2));
                done_d = (cnt_q == '0);
            end
            default: tms_d = 1'b1;
        endcase
    end

    assign bus_if.tms       = tms_q;
    assign bus_if.tdi       = tdi_q;
    assign bus_if.busy      = (st_q != StIdle);
    assign bus_if.done      = done_q;
    assign bus_if.data_out  = dout_q;
    assign bus_if.tap_state = tap_q;

endmodule
